// File: rtl/mul_share_arbiter_if.sv
// rtl/mul_share_arbiter_if.sv - requester and shared-multiplier signal bundle for mul_share_arbiter
interface mul_share_arbiter_if #(
  parameter int N = 16
);
  logic         req0_valid;
  logic [7:0]   req0_a;
  logic [7:0]   req0_b;
  logic         req0_done;
  logic [N-1:0] req0_prod;
  logic         req0_err;
  logic         req1_valid;
  logic [7:0]   req1_a;
  logic [7:0]   req1_b;
  logic         req1_done;
  logic [N-1:0] req1_prod;
  logic         req1_err;
  logic [N-1:0] mul_ip_BA;
  logic         mul_start;
  logic         mul_ready;
  logic [N-1:0] mul_op_prod;
  logic         busy;
  logic         grant_id;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  mul_ready, mul_op_prod,
    output req0_done, req0_prod, req0_err, req1_done, req1_prod, req1_err,
    output mul_ip_BA, mul_start, busy, grant_id
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output mul_ready, mul_op_prod,
    input  req0_done, req0_prod, req0_err, req1_done, req1_prod, req1_err,
    input  mul_ip_BA, mul_start, busy, grant_id
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - two-requester round-robin arbiter for a shared multiplier; MUL_TIMEOUT_EN adds a WAIT timeout
module mul_share_arbiter #(
  parameter int         N       = 16,
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic               clk,
  input  logic               reset,
  mul_share_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]   state;
  logic         ptr;
  logic         pick;
  logic         grant_q;
  logic         busy_q;
  logic         start_q;
  logic         done0_q;
  logic         done1_q;
  logic [N-1:0] ba_q;
  logic [N-1:0] prod0_q;
  logic [N-1:0] prod1_q;

`ifdef MUL_TIMEOUT_EN
  logic [7:0] cnt;
  logic [7:0] cnt_inc;
  logic       err0_q;
  logic       err1_q;
  assign cnt_inc = cnt + 8'd1;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // The pointer only breaks ties; a lone requester always wins.
  always_comb begin
    pick = 1'b0;
    if (bus.req0_valid && bus.req1_valid) pick = ptr;
    else                                  pick = bus.req1_valid;
  end

  // Arbitration FSM with registered outputs; pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      grant_q <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      ba_q    <= '0;
      prod0_q <= '0;
      prod1_q <= '0;
`ifdef MUL_TIMEOUT_EN
      cnt     <= '0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0_valid || bus.req1_valid) begin
            ba_q    <= pick ? N'({bus.req1_b, bus.req1_a}) : N'({bus.req0_b, bus.req0_a});
            grant_q <= pick;
            busy_q  <= 1'b1;
            start_q <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef MUL_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        WAIT: begin
          if (bus.mul_ready) begin
            if (grant_q) begin
              prod1_q <= bus.mul_op_prod;
              done1_q <= 1'b1;
            end else begin
              prod0_q <= bus.mul_op_prod;
              done0_q <= 1'b1;
            end
            state <= RESP;
          end
`ifdef MUL_TIMEOUT_EN
          // Times out in the WAIT cycle that brings the count up to TIMEOUT.
          else if (cnt_inc == TIMEOUT) begin
            if (grant_q) begin
              prod1_q <= '0;
              err1_q  <= 1'b1;
              done1_q <= 1'b1;
            end else begin
              prod0_q <= '0;
              err0_q  <= 1'b1;
              done0_q <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt_inc;
          end
`endif
        end
        RESP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          ptr    <= ~grant_q;
`ifdef MUL_TIMEOUT_EN
          err0_q <= 1'b0;
          err1_q <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mul_ip_BA = ba_q;
  assign bus.mul_start = start_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = grant_q;
  assign bus.req0_done = done0_q;
  assign bus.req1_done = done1_q;
  assign bus.req0_prod = prod0_q;
  assign bus.req1_prod = prod1_q;
`ifdef MUL_TIMEOUT_EN
  assign bus.req0_err  = err0_q;
  assign bus.req1_err  = err1_q;
`else
  assign bus.req0_err  = 1'b0;
  assign bus.req1_err  = 1'b0;
`endif
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - directed self-checking bench for mul_share_arbiter
module tb_mul_share_arbiter;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [15:0] ep0;
  logic [15:0] ep1;

  mul_share_arbiter_if #(.N(16)) bus ();

  mul_share_arbiter #(.N(16), .TIMEOUT(8'd10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    ep0 = 16'h0;
    ep1 = 16'h0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
    check({tag, "_grant"}, 32'(bus.grant_id), 32'd0);
    check({tag, "_start"}, 32'(bus.mul_start), 32'd0);
    check({tag, "_ba"},    32'(bus.mul_ip_BA), 32'h0);
    check({tag, "_done"},  32'({bus.req1_done, bus.req0_done}), 32'd0);
    check({tag, "_err"},   32'({bus.req1_err, bus.req0_err}), 32'd0);
    check({tag, "_prod0"}, 32'(bus.req0_prod), 32'h0);
    check({tag, "_prod1"}, 32'(bus.req1_prod), 32'h0);
  endtask

  // One full operation starting from IDLE with the requester(s) already valid.
  task automatic run_op(input logic g, input logic [15:0] ba, input logic [15:0] p);
    tick();
    check("op_grant", 32'(bus.grant_id), 32'(g));
    check("op_ba", 32'(bus.mul_ip_BA), 32'(ba));
    check("op_start", 32'(bus.mul_start), 32'd1);
    check("op_busy", 32'(bus.busy), 32'd1);
    tick();
    check("op_start_off", 32'(bus.mul_start), 32'd0);
    bus.mul_ready = 1'b1;
    bus.mul_op_prod = p;
    tick();
    bus.mul_ready = 1'b0;
    if (g) ep1 = p; else ep0 = p;
    check("op_done", 32'({bus.req1_done, bus.req0_done}), g ? 32'd2 : 32'd1);
    check("op_prod0", 32'(bus.req0_prod), 32'(ep0));
    check("op_prod1", 32'(bus.req1_prod), 32'(ep1));
    tick();
    check("op_done_off", 32'({bus.req1_done, bus.req0_done}), 32'd0);
    check("op_idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_a = 8'h0; bus.req0_b = 8'h0;
    bus.req1_valid = 1'b0; bus.req1_a = 8'h0; bus.req1_b = 8'h0;
    bus.mul_ready = 1'b0;  bus.mul_op_prod = 16'h0;

    do_reset();
    check_idle_outputs("reset");

    // Single request, 12 x 10, ready in the first WAIT cycle.
    bus.req0_a = 8'h0C; bus.req0_b = 8'h0A; bus.req0_valid = 1'b1;
    tick();
    check("a_ba", 32'(bus.mul_ip_BA), 32'h0A0C);
    check("a_start", 32'(bus.mul_start), 32'd1);
    check("a_done_c1", 32'(bus.req0_done), 32'd0);
    tick();
    check("a_start_once", 32'(bus.mul_start), 32'd0);
    check("a_done_c2", 32'(bus.req0_done), 32'd0);
    bus.mul_ready = 1'b1; bus.mul_op_prod = 16'h0078;
    tick();
    bus.mul_ready = 1'b0; bus.req0_valid = 1'b0;
    check("a_done_c3", 32'(bus.req0_done), 32'd1);
    check("a_prod", 32'(bus.req0_prod), 32'h0078);
    check("a_done1", 32'(bus.req1_done), 32'd0);
    tick();
    check("a_done_off", 32'(bus.req0_done), 32'd0);
    check("a_busy_off", 32'(bus.busy), 32'd0);
    check("a_prod_hold", 32'(bus.req0_prod), 32'h0078);

    // Both requesters held valid from reset: grants alternate 0,1,0,1.
    do_reset();
    bus.req0_a = 8'h03; bus.req0_b = 8'h05; bus.req0_valid = 1'b1;
    bus.req1_a = 8'h07; bus.req1_b = 8'h09; bus.req1_valid = 1'b1;
    run_op(1'b0, 16'h0503, 16'h000F);
    run_op(1'b1, 16'h0907, 16'h003F);
    run_op(1'b0, 16'h0503, 16'h000F);
    run_op(1'b1, 16'h0907, 16'h003F);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

    // Lone req1 with the multiplier never answering.
    bus.req1_a = 8'h04; bus.req1_b = 8'h06; bus.req1_valid = 1'b1;
    bus.mul_op_prod = 16'h1234;
    tick();
    check("t_grant", 32'(bus.grant_id), 32'd1);
    check("t_ba", 32'(bus.mul_ip_BA), 32'h0604);
    tick();
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("t_wait_done", 32'(bus.req1_done), 32'd0);
      check("t_wait_busy", 32'(bus.busy), 32'd1);
    end
    tick();
`ifdef MUL_TIMEOUT_EN
    check("t_done", 32'(bus.req1_done), 32'd1);
    check("t_err", 32'(bus.req1_err), 32'd1);
    check("t_prod", 32'(bus.req1_prod), 32'h0);
    check("t_prod0", 32'(bus.req0_prod), 32'h000F);
    bus.req1_valid = 1'b0;
    tick();
    check("t_done_off", 32'(bus.req1_done), 32'd0);
    check("t_err_off", 32'(bus.req1_err), 32'd0);
    check("t_busy_off", 32'(bus.busy), 32'd0);
`else
    for (int i = 0; i < 10; i++) begin
      check("t_stuck_done", 32'({bus.req1_done, bus.req1_err}), 32'd0);
      check("t_stuck_busy", 32'(bus.busy), 32'd1);
      tick();
    end
    check("t_prod_hold", 32'(bus.req1_prod), 32'h003F);
    bus.req1_valid = 1'b0;
`endif

    // Reset in the middle of WAIT abandons the operation.
    do_reset();
    bus.req0_a = 8'h02; bus.req0_b = 8'h03; bus.req0_valid = 1'b1;
    tick();
    tick();
    tick();
    check("r_busy_wait", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    tick();
    check_idle_outputs("r_abort");
    reset = 1'b1;
    bus.req0_valid = 1'b0;
    bus.mul_ready = 1'b1; bus.mul_op_prod = 16'h0006;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r_no_start", 32'(bus.mul_start), 32'd0);
      check("r_no_done", 32'({bus.req1_done, bus.req0_done}), 32'd0);
      check("r_no_busy", 32'(bus.busy), 32'd0);
    end
    bus.mul_ready = 1'b0;

    // Stray mul_ready in IDLE, then req1 operands change after the grant.
    bus.mul_ready = 1'b1; bus.mul_op_prod = 16'hBEEF;
    tick();
    check("e_idle_busy", 32'(bus.busy), 32'd0);
    check("e_idle_prod", 32'({bus.req1_prod, bus.req0_prod}), 32'h0);
    bus.mul_ready = 1'b0;
    bus.req1_a = 8'h11; bus.req1_b = 8'h02; bus.req1_valid = 1'b1;
    tick();
    check("e_ba", 32'(bus.mul_ip_BA), 32'h0211);
    check("e_grant", 32'(bus.grant_id), 32'd1);
    bus.req1_a = 8'hFF; bus.req1_b = 8'hFF; bus.req1_valid = 1'b0;
    tick();
    check("e_ba_latched", 32'(bus.mul_ip_BA), 32'h0211);
    bus.mul_ready = 1'b1; bus.mul_op_prod = 16'h0022;
    tick();
    bus.mul_ready = 1'b0;
    check("e_done", 32'({bus.req1_done, bus.req0_done}), 32'd2);
    check("e_prod1", 32'(bus.req1_prod), 32'h0022);
    check("e_prod0", 32'(bus.req0_prod), 32'h0);
    tick();
    check("e_done_off", 32'(bus.req1_done), 32'd0);
    tick();
    check("e_stay_idle", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_share_arbiter.md
MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 The module SHALL have parameter N, default 16, giving the product and operand-bus width (two 8-bit operands).
REQ-002 The module SHALL have parameter TIMEOUT, default 8'd255, giving the WAIT-state cycle limit (used only with MUL_TIMEOUT_EN).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: the reset, which is synchronous and active-low.
REQ-005 The module SHALL have ports reqN_valid, input, 1 bit (N=0,1): requester N holds this high with operands stable until it sees reqN_done.
REQ-006 The module SHALL have ports reqN_a and reqN_b, input, 8 bits each: requester N's operands A and B.
REQ-007 The module SHALL have ports reqN_done, output, 1 bit: a single-cycle pulse marking completion for requester N.
REQ-008 The module SHALL have ports reqN_prod, output, N bits: requester N's product register, held until its next completion.
REQ-009 The module SHALL have ports reqN_err, output, 1 bit: set with reqN_done when the operation timed out.
REQ-010 The module SHALL have port mul_ip_BA, output, N bits: multiplier operands, with B at [15:8] and A at [7:0].
REQ-011 The module SHALL have port mul_start, output, 1 bit: a one-cycle start pulse to the multiplier interface.
REQ-012 The module SHALL have port mul_ready, input, 1 bit: the multiplier result-valid signal.
REQ-013 The module SHALL have port mul_op_prod, input, N bits: the multiplier product.
REQ-014 The module SHALL have ports busy and grant_id, outputs, 1 bit each: busy is high in any state except IDLE; grant_id is the index of the current owner.

Function
REQ-015 The state machine SHALL have exactly the states IDLE, ISSUE, WAIT and RESP, and all outputs SHALL be registered.
REQ-016 In IDLE with any reqN_valid high, the module SHALL:
- latch {reqN_b, reqN_a} of the chosen requester into mul_ip_BA;
- set grant_id;
- go to ISSUE on the next edge.
REQ-017 Arbitration SHALL be round-robin with a 1-bit priority pointer:
- when both requesters are valid, the pointer's requester wins;
- when only one is valid, that requester wins regardless of the pointer.
REQ-018 The pointer SHALL move to the non-granted index at each RESP, so simultaneous requests alternate 0,1,0,1.
REQ-019 In ISSUE, mul_start SHALL be 1 for exactly one cycle, followed by an unconditional move to WAIT.
REQ-020 In WAIT, mul_ready SHALL be sampled starting the cycle after mul_start. When it is 1, mul_op_prod SHALL be captured into req[grant_id]_prod and the FSM SHALL go to RESP.
REQ-021 In RESP, req[grant_id]_done SHALL be 1 for exactly one cycle, followed by a move to IDLE.
REQ-022 The other requester's done and prod SHALL be unaffected during RESP.
REQ-023 Minimum latency SHALL be 4 cycles from reqN_valid sampled in IDLE to reqN_done high, given mul_ready the first WAIT cycle.
REQ-024 Back-to-back operation SHALL leave at least one IDLE cycle between RESP and the next ISSUE.
REQ-025 Operand changes or valid deassertion after the grant SHALL be ignored, because the operands are latched.
REQ-026 A requester still valid in the cycle after its done SHALL be treated as a new request.
REQ-027 mul_ready asserted outside WAIT SHALL be ignored.
REQ-028 Products SHALL be the unmodified N-bit multiplier output, with no truncation or sign handling.

Reset
REQ-029 With reset==0 at a rising edge, the module SHALL enter IDLE and set pointer=0. It SHALL also clear mul_ip_BA, mul_start, reqN_done, reqN_prod, reqN_err, busy and grant_id to 0.
REQ-030 Reset asserted mid-operation SHALL abandon the operation with no done pulse, and reset SHALL take priority over all other events.

Configuration
REQ-031 With macro MUL_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle without mul_ready.
REQ-032 When that counter equals TIMEOUT, the module SHALL go to RESP with req[grant_id]_prod=0 and req[grant_id]_err=1 for the done cycle. mul_ready in the same cycle as the timeout SHALL win.
REQ-033 Without MUL_TIMEOUT_EN, WAIT SHALL last indefinitely, reqN_err SHALL be constant 0, and no counter logic SHALL exist.

Verification
REQ-034 Verification SHALL cover: req0 A=8'h0C, B=8'h0A, mul_ready 1 cycle after start, product 16'h0078 -> mul_ip_BA=16'h0A0C, req0_prod=16'h0078, req0_done one pulse 4 cycles after valid.
REQ-035 Verification SHALL cover: both valid from reset (req0 3x5, req1 7x9) -> req0 served first (16'h000F), then req1 (16'h003F), with exactly one done pulse each.
REQ-036 Verification SHALL cover: both held valid for 4 operations -> grant_id sequence 0,1,0,1 and busy low exactly one cycle between operations.
REQ-037 Verification SHALL cover: reset driven low during WAIT -> next cycle IDLE, all outputs 0, no reqN_done pulse, and no start when mul_ready arrives later.
REQ-038 Verification SHALL cover, with MUL_TIMEOUT_EN and TIMEOUT=10, mul_ready never asserted -> req1_done with req1_err=1 and req1_prod=0 after 10 WAIT cycles; the same test without the macro SHALL keep the FSM in WAIT with busy=1.
REQ-039 Verification SHALL cover: mul_ready pulsed in IDLE, then req1 changes operands after the grant -> no effect, and the product uses the latched operands.
